// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and load scoreboard for a single-write-port register file.
// Define RF_WB_RR_EN for round-robin arbitration; the default build gives port L fixed priority.
module rf_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [ADDR_W-1:0] alu_addr_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    input  logic              issue_load_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              err_o
);
    localparam int NREG = 1 << ADDR_W;

    // Handshake: a port transfers when valid && ready at a rising edge; ready is only
    // raised for a valid port, and a losing port holds valid/addr/data until granted.
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              contended;
    logic              grant_a;
    logic              grant_l;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_dup;
    logic              waw_a;
    logic              issue_set;
`ifdef RF_WB_RR_EN
    logic              favour_l;
`endif

    always_comb begin
        contended = alu_valid_i && lsu_valid_i;
        grant_a   = 1'b0;
        grant_l   = 1'b0;
        if (!rst_i) begin
            if (contended) begin
`ifdef RF_WB_RR_EN
                grant_l = favour_l;
                grant_a = !favour_l;
`else
                grant_l = 1'b1;
`endif
            end else begin
                grant_a = alu_valid_i;
                grant_l = lsu_valid_i;
            end
        end
    end

    assign alu_ready_o = grant_a;
    assign lsu_ready_o = grant_l;

    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = alu_addr_i;
        wr_data  = alu_data_i;
        if (grant_l) begin
            wr_valid = (lsu_addr_i != '0);
            wr_addr  = lsu_addr_i;
            wr_data  = lsu_data_i;
        end else if (grant_a) begin
            wr_valid = (alu_addr_i != '0);
        end
    end

    // A fresh load on the same edge as its write-back keeps the bit set.
    always_comb begin
        issue_set = issue_load_i && (issue_addr_i != '0);
        issue_dup = issue_set && busy[issue_addr_i] &&
                    !(grant_l && (lsu_addr_i == issue_addr_i));
        waw_a     = grant_a && (alu_addr_i != '0) && busy[alu_addr_i];
        busy_next = busy;
        if (grant_l) busy_next[lsu_addr_i] = 1'b0;
        if (issue_set) busy_next[issue_addr_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            err_o      <= 1'b0;
            busy       <= '0;
`ifdef RF_WB_RR_EN
            favour_l   <= 1'b1;
`endif
        end else begin
            rf_we_o <= wr_valid;
            if (wr_valid) begin
                rf_waddr_o <= wr_addr;
                rf_wdata_o <= wr_data;
            end
            if (issue_dup || waw_a) err_o <= 1'b1;
            busy <= busy_next;
`ifdef RF_WB_RR_EN
            if (contended) favour_l <= grant_a;
`endif
        end
    end

    // The in-flight term covers the cycle between grant and register-file commit.
    assign rs1_busy_o = busy[rs1_addr_i] |
                        (rf_we_o && (rf_waddr_o == rs1_addr_i) && (rs1_addr_i != '0));
    assign rs2_busy_o = busy[rs2_addr_i] |
                        (rf_we_o && (rf_waddr_o == rs2_addr_i) && (rs2_addr_i != '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a register-level reference model.
module tb_rf_wb_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i, lsu_valid_i, issue_load_i;
    logic [4:0]  alu_addr_i, lsu_addr_i, issue_addr_i, rs1_addr_i, rs2_addr_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o, rf_we_o, err_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    rf_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
        .issue_load_i(issue_load_i), .issue_addr_i(issue_addr_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic iss, input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2);
        rst_i = rst; alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
        lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
        issue_load_i = iss; issue_addr_i = ia; rs1_addr_i = r1; rs2_addr_i = r2;
    endtask

    typedef struct {
        logic rst; logic av; logic [4:0] aa; logic [31:0] ad;
        logic lv; logic [4:0] la; logic [31:0] ld;
        logic iss; logic [4:0] ia; logic [4:0] r1; logic [4:0] r2;
        logic ear; logic elr; logic er1; logic er2;
        logic ewe; logic [4:0] ewa; logic [31:0] ewd; logic eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic av, logic [4:0] aa, logic [31:0] ad,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic iss, logic [4:0] ia, logic [4:0] r1, logic [4:0] r2,
                                logic ear, logic elr, logic er1, logic er2,
                                logic ewe, logic [4:0] ewa, logic [31:0] ewd, logic eerr);
        vec_t v;
        v.rst = rst; v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
        v.iss = iss; v.ia = ia; v.r1 = r1; v.r2 = r2;
        v.ear = ear; v.elr = elr; v.er1 = er1; v.er2 = er2;
        v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.eerr = eerr;
        return v;
    endfunction

    // Reference model state
    bit          busy_m[32];
    bit          err_m, m_we, last_win_l;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [4:0]  load_q[$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        err_m = 1'b0; m_we = 1'b0; m_wa = '0; m_wd = '0;
        last_win_l = 1'b0;  // last contended winner was A, so L is favoured next
        load_q.delete();
    endtask

    initial begin
        bit          a_pend, l_pend, ga, gl, win_l, iss, rst, exp_r1, exp_r2, first_l;
        logic [4:0]  a_addr, l_addr, ia, r1, r2;
        logic [31:0] a_data, l_data;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_we", rf_we_o, 0);
        chk("reset_waddr", rf_waddr_o, 0);
        chk("reset_wdata", rf_wdata_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_alu_ready", alu_ready_o, 0);
        chk("reset_lsu_ready", lsu_ready_o, 0);

        //            rst av aa ad            lv la ld    iss ia r1  r2  ear elr r1b r2b we wa wd           err
        vecs.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,    0, 0,  0,  0,  1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  5,  0,  0, 0, 1, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  5,  0,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 0,  0,  0, 1, 0, 0, 1, 4, 32'h22,       0));
        vecs.push_back(mk(0, 1, 3, 32'h11,       0, 0, 0,    0, 0,  0,  0,  1, 0, 0, 0, 1, 3, 32'h11,       0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    1, 7,  7,  0,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  7,  0,  0, 0, 1, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 7, 32'h77, 0, 0, 7,  0,  0, 1, 1, 0, 1, 7, 32'h77,       0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  7,  0,  0, 0, 1, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  7,  0,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,    0, 0,  0,  0,  1, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    1, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    1, 9,  0,  9,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 9, 32'h99, 1, 9, 0,  9,  0, 1, 0, 1, 1, 9, 32'h99,       0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  0,  9,  0, 0, 0, 1, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    1, 9,  0,  9,  0, 0, 0, 1, 0, 0, 0,            1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  0,  9,  0, 0, 0, 1, 0, 0, 0,            1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    1, 12, 12, 9,  0, 0, 0, 1, 0, 0, 0,            1));
        vecs.push_back(mk(1, 1, 3, 32'h33,       1, 4, 32'h44, 1, 12, 12, 9, 0, 0, 1, 1, 0, 0, 0,            0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0, 0,    0, 0,  12, 9,  0, 0, 0, 0, 0, 0, 0,            0));
        vecs.push_back(mk(0, 1, 3, 32'h33,       1, 4, 32'h44, 0, 0, 0,  0,  0, 1, 0, 0, 1, 4, 32'h44,       0));
        vecs.push_back(mk(0, 1, 3, 32'h33,       0, 0, 0,    0, 0,  0,  0,  1, 0, 0, 0, 1, 3, 32'h33,       0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk_i);
            drive(v.rst, v.av, v.aa, v.ad, v.lv, v.la, v.ld, v.iss, v.ia, v.r1, v.r2);
            #1;
            chk($sformatf("vec%0d_alu_ready", i), alu_ready_o, v.ear);
            chk($sformatf("vec%0d_lsu_ready", i), lsu_ready_o, v.elr);
            chk($sformatf("vec%0d_rs1_busy", i), rs1_busy_o, v.er1);
            chk($sformatf("vec%0d_rs2_busy", i), rs2_busy_o, v.er2);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d_we", i), rf_we_o, v.ewe);
            if (v.ewe) begin
                chk($sformatf("vec%0d_waddr", i), rf_waddr_o, v.ewa);
                chk($sformatf("vec%0d_wdata", i), rf_wdata_o, v.ewd);
            end
            if (v.rst) begin
                chk($sformatf("vec%0d_rst_waddr", i), rf_waddr_o, 0);
                chk($sformatf("vec%0d_rst_wdata", i), rf_wdata_o, 0);
            end
            chk($sformatf("vec%0d_err", i), err_o, v.eerr);
        end

        // Second contention: the last contended cycle granted L, so round-robin now picks A.
`ifdef RF_WB_RR_EN
        first_l = 1'b0;
`else
        first_l = 1'b1;
`endif
        @(negedge clk_i);
        drive(0, 1, 3, 32'h55, 1, 4, 32'h66, 0, 0, 0, 0);
        #1;
        chk("rr2_alu_ready", alu_ready_o, !first_l);
        chk("rr2_lsu_ready", lsu_ready_o, first_l);
        @(posedge clk_i); #1;
        chk("rr2_first_waddr", rf_waddr_o, first_l ? 4 : 3);
        @(negedge clk_i);
        if (first_l) drive(0, 1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        else         drive(0, 0, 0, 0, 1, 4, 32'h66, 0, 0, 0, 0);
        #1;
        chk("rr2_loser_ready", first_l ? alu_ready_o : lsu_ready_o, 1);
        @(posedge clk_i); #1;
        chk("rr2_second_waddr", rf_waddr_o, first_l ? 3 : 4);
        chk("rr2_second_wdata", rf_wdata_o, first_l ? 32'h55 : 32'h66);

        // Port A write to a register with an outstanding load.
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        drive(0, 1, 10, 32'h1, 0, 0, 0, 0, 0, 10, 0);
        #1;
        chk("waw_alu_ready", alu_ready_o, 1);
        chk("waw_rs1_busy_pre", rs1_busy_o, 1);
        @(posedge clk_i); #1;
        chk("waw_err", err_o, 1);
        @(negedge clk_i);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0);
        @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("waw_busy_kept", rs1_busy_o, 1);

        // Randomized traffic against the reference model.
        @(negedge clk_i);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        model_reset();
        a_pend = 0; l_pend = 0; a_addr = 0; l_addr = 0; a_data = 0; l_data = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk_i);
            rst = (cyc % 250 == 249);
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_addr = 5'($urandom_range(0, 31));
                if (busy_m[a_addr]) a_addr = 0;
                a_data = $urandom;
                a_pend = 1;
            end
            if (!l_pend && load_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                l_addr = load_q.pop_front();
                l_data = $urandom;
                l_pend = 1;
            end
            iss = 0;
            ia = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0 && !busy_m[ia] && !(a_pend && a_addr == ia)) iss = 1;
            r1 = 5'($urandom_range(0, 31));
            r2 = (cyc % 3 == 0) ? m_wa : 5'($urandom_range(0, 31));
            drive(rst, a_pend, a_addr, a_data, l_pend, l_addr, l_data, iss, ia, r1, r2);

            ga = 0; gl = 0;
            if (!rst) begin
                if (a_pend && l_pend) begin
`ifdef RF_WB_RR_EN
                    win_l = !last_win_l;
`else
                    win_l = 1'b1;
`endif
                    gl = win_l; ga = !win_l;
                end else begin
                    ga = a_pend; gl = l_pend;
                end
            end
            exp_r1 = busy_m[r1] || (m_we && m_wa == r1 && r1 != 0);
            exp_r2 = busy_m[r2] || (m_we && m_wa == r2 && r2 != 0);
            #1;
            chk("rnd_alu_ready", alu_ready_o, ga);
            chk("rnd_lsu_ready", lsu_ready_o, gl);
            chk("rnd_rs1_busy", rs1_busy_o, exp_r1);
            chk("rnd_rs2_busy", rs2_busy_o, exp_r2);

            @(posedge clk_i);
            if (rst) begin
                model_reset();
                a_pend = 0; l_pend = 0;
            end else begin
                if (ga && gl) ;  // unreachable: at most one grant per cycle
                if (a_pend && l_pend) last_win_l = gl;
                if (iss && ia != 0 && busy_m[ia] && !(gl && l_addr == ia)) err_m = 1;
                if (ga && a_addr != 0 && busy_m[a_addr]) err_m = 1;
                m_we = 0;
                if (gl && l_addr != 0) begin m_we = 1; m_wa = l_addr; m_wd = l_data; end
                if (ga && a_addr != 0) begin m_we = 1; m_wa = a_addr; m_wd = a_data; end
                if (gl) busy_m[l_addr] = 0;
                if (iss && ia != 0) begin
                    busy_m[ia] = 1;
                    load_q.push_back(ia);
                end
                if (ga) a_pend = 0;
                if (gl) l_pend = 0;
            end
            #1;
            chk("rnd_we", rf_we_o, m_we);
            if (m_we) begin
                chk("rnd_waddr", rf_waddr_o, m_wa);
                chk("rnd_wdata", rf_wdata_o, m_wd);
            end
            chk("rnd_err", err_o, err_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32x32 RISC-V register file, which has one write port.
- Shares that write port between two requesters: ALU/CSR write-back (port A) and load-store-unit write-back (port L). Each uses a valid/ready handshake.
- Tracks registers with outstanding loads and reports read-after-write hazards on the two decode read addresses, so the core can stall.
- Sits between execute/LSU and the register file. Drives the register file's write_enable/addr/data directly from registered outputs.

Parameters:
ADDR_W, 5, register index width (2**ADDR_W registers)
DATA_W, 32, write data width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
alu_valid_i  in  1  port A write request
alu_ready_o  out  1  port A granted this cycle (combinational)
alu_addr_i  in  ADDR_W  port A destination register
alu_data_i  in  DATA_W  port A write data
lsu_valid_i  in  1  port L write request
lsu_ready_o  out  1  port L granted this cycle (combinational)
lsu_addr_i  in  ADDR_W  port L destination register
lsu_data_i  in  DATA_W  port L write data
issue_load_i  in  1  a load has been issued; mark its destination pending
issue_addr_i  in  ADDR_W  destination of the issued load
rs1_addr_i  in  ADDR_W  decode read address 1
rs2_addr_i  in  ADDR_W  decode read address 2
rs1_busy_o  out  1  rs1 has a pending or in-flight write (combinational)
rs2_busy_o  out  1  rs2 has a pending or in-flight write (combinational)
rf_we_o  out  1  register file write enable (registered)
rf_waddr_o  out  ADDR_W  register file write address (registered)
rf_wdata_o  out  DATA_W  register file write data (registered)
err_o  out  1  sticky protocol error flag (registered)

Behaviour:
Reset (rst_i=1 at an edge):
- rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, err_o=0.
- All busy bits cleared; round-robin pointer set to favour L.
- While rst_i=1, ready outputs are 0 and the scoreboard ignores issue_load_i.
- A request pending when reset asserts is dropped; it is not replayed.

Handshake and grant:
- A transfer occurs when valid && ready are both high at a rising edge.
- At most one port is granted per cycle; ready is 0 unless valid is 1.
- Only one port valid: that port is granted.
- Both ports valid: grant per the arbitration policy (Optional Feature). The loser's ready=0; it holds valid, addr and data stable until granted.

Write timing:
- An accepted transfer at edge N gives rf_we_o=1 with that addr/data during cycle N+1; the register file commits at edge N+1.
- No accepted transfer at edge N gives rf_we_o=0 in cycle N+1; addr/data hold their last values.
- Transfer with addr=0: handshake completes, but rf_we_o stays 0 (x0 is never written).

Scoreboard:
- One busy bit per register; bit 0 is tied to 0.
- Set: issue_load_i=1 with issue_addr_i!=0.
- Clear: a port L transfer to that address is accepted.
- Set and clear on the same address at the same edge: set wins (the new load is still outstanding).
- issue_load_i to an address that is already busy and not being cleared that edge sets err_o=1, sticky until reset. The bit stays set.
- rsX_busy_o = busy[rsX_addr_i] | (rf_we_o && rf_waddr_o==rsX_addr_i && rsX_addr_i!=0). This covers the cycle in which the write is in flight.
- A port A transfer to a busy register does not clear its busy bit. It sets err_o, because a WAW against an outstanding load is illegal.

Optional Feature:
Macro RF_WB_RR_EN.
- Defined: round-robin arbitration.
  - On contention, grant the port not granted at the last contended cycle.
  - Pointer updates only on contended grants.
  - Reset state favours L.
- Undefined: fixed priority, L always wins over A. The pointer logic is absent.

Test Plan:
1. Reset, then alu_valid_i=1, addr=5, data=0xDEADBEEF -> alu_ready_o=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; following cycle rf_we_o=0.
2. Both valid, A addr=3 data=0x11, L addr=4 data=0x22, held three cycles -> fixed priority: L, A, then idle. With RF_WB_RR_EN: first two grants still L then A; a second contention grants A first.
3. issue_load_i addr=7, rs1_addr_i=7 -> rs1_busy_o=1 from next cycle. L transfer to 7 at edge N -> busy bit clears at N, rs1_busy_o still 1 in cycle N+1 via the in-flight term, 0 in cycle N+2.
4. A transfer addr=0 data=0xFFFFFFFF -> alu_ready_o=1, rf_we_o stays 0. issue_load_i addr=0 -> rs1_busy_o (rs1=0) stays 0.
5. issue_load_i addr=9 twice without write-back -> err_o=1 after the second edge, held until rst_i. Same edge as an L write-back to 9 -> err_o stays 0 and busy[9] stays 1.
6. Assert rst_i mid-contention with busy[12]=1 -> next cycle all busy outputs 0, rf_we_o=0, err_o=0, readies 0 while rst_i=1.
